alu_result_checker: RTL and testbench

- Synthesizable response-side companion to the 64-bit ALU: consumes the operand/opcode tuples presented to the ALU, plus the ALU's `out`.
- Recomputes the expected result in a 2-stage pipeline and compares it against the ALU output.
- Counts checked/failed operations and captures the first failing tuple.
- Lets ALU self-test run on hardware or in regression without a behavioural scoreboard.

---
 rtl/alu_chk_pkg.sv | 20 ++
 rtl/alu_ref_model.sv | 28 ++
 rtl/alu_result_checker.sv | 193 +++++++++++++++++++
 tb/tb_alu_result_checker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg: shared definitions for the ALU result checker.
//   - DEFAULT_WIDTH : default operand/result width
//   - OP_*          : ALU control codes
//   - chk_state_e   : checker FSM states
package alu_chk_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected-result function of the 64-bit ALU.
// Ports:
//   a, b  in  WIDTH  operands
//   cont  in  2      control code (add / sub / and / or)
//   res   out WIDTH  expected result, modulo 2^WIDTH
module alu_ref_model
    import alu_chk_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       cont,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        unique case (cont)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes the ALU result in a 2-stage pipeline, compares it with the
// ALU output, counts checked/failed operations and captures the first failing tuple.
// Ports:
//   clk, rst_n (sync, active-low), start/clear pulses
//   in_valid/in_ready handshake; op_a, op_b, op_cont, alu_out tuple
//   busy, checked_cnt, fail_cnt, fail_flag, halted status
//   cap_a, cap_b, cap_cont, cap_got, cap_exp first-failure capture
//   sig (only with ALU_CHK_SIGNATURE_EN defined) running signature of compared results
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned CNT_W        = 32,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_cont,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_flag,
    output logic             halted,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [1:0]       cap_cont,
    output logic [WIDTH-1:0] cap_got,
    output logic [WIDTH-1:0] cap_exp
`ifdef ALU_CHK_SIGNATURE_EN
    ,
    output logic [WIDTH-1:0] sig
`endif
);

    chk_state_e state_q, state_d;

    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_got_q;
    logic [1:0]       s1_cont_q, s2_cont_q;
    logic [WIDTH-1:0] s2_a_q, s2_b_q, s2_got_q, s2_exp_q;
    logic [WIDTH-1:0] s1_exp;

    logic [CNT_W-1:0] checked_q, checked_d, fail_q, fail_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    logic [WIDTH-1:0] cap_got_q, cap_got_d, cap_exp_q, cap_exp_d;
    logic [1:0]       cap_cont_q, cap_cont_d;

    logic accept, mismatch;

    assign in_ready = (state_q == StRun);
    assign halted   = (state_q == StHalt);
    assign accept   = in_valid & in_ready;
    assign busy     = s1_valid_q | s2_valid_q;
    assign mismatch = s2_valid_q & (s2_got_q != s2_exp_q);

    alu_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .cont(s1_cont_q),
        .res (s1_exp)
    );

    // FSM next state; clear wins over start and over a compare
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (mismatch && STOP_ON_FAIL) state_d = StHalt;
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    // Counters and capture; in-flight compares still count after HALT
    always_comb begin
        checked_d  = checked_q;
        fail_d     = fail_q;
        flag_d     = flag_q;
        cap_a_d    = cap_a_q;
        cap_b_d    = cap_b_q;
        cap_cont_d = cap_cont_q;
        cap_got_d  = cap_got_q;
        cap_exp_d  = cap_exp_q;
        if (clear) begin
            checked_d  = '0;
            fail_d     = '0;
            flag_d     = 1'b0;
            cap_a_d    = '0;
            cap_b_d    = '0;
            cap_cont_d = '0;
            cap_got_d  = '0;
            cap_exp_d  = '0;
        end else if (s2_valid_q) begin
            if (checked_q != '1) checked_d = checked_q + CNT_W'(1);
            if (mismatch) begin
                if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                if (!flag_q) begin
                    cap_a_d    = s2_a_q;
                    cap_b_d    = s2_b_q;
                    cap_cont_d = s2_cont_q;
                    cap_got_d  = s2_got_q;
                    cap_exp_d  = s2_exp_q;
                    flag_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            checked_q  <= '0;
            fail_q     <= '0;
            flag_q     <= 1'b0;
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            cap_cont_q <= '0;
            cap_got_q  <= '0;
            cap_exp_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= clear ? 1'b0 : accept;
            s2_valid_q <= clear ? 1'b0 : s1_valid_q;
            checked_q  <= checked_d;
            fail_q     <= fail_d;
            flag_q     <= flag_d;
            cap_a_q    <= cap_a_d;
            cap_b_q    <= cap_b_d;
            cap_cont_q <= cap_cont_d;
            cap_got_q  <= cap_got_d;
            cap_exp_q  <= cap_exp_d;
        end
    end

    // Pipeline data needs no reset: it is only consumed under its valid bit
    always_ff @(posedge clk) begin
        s1_a_q    <= op_a;
        s1_b_q    <= op_b;
        s1_cont_q <= op_cont;
        s1_got_q  <= alu_out;
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_cont_q <= s1_cont_q;
        s2_got_q  <= s1_got_q;
        s2_exp_q  <= s1_exp;
    end

    assign checked_cnt = checked_q;
    assign fail_cnt    = fail_q;
    assign fail_flag   = flag_q;
    assign cap_a       = cap_a_q;
    assign cap_b       = cap_b_q;
    assign cap_cont    = cap_cont_q;
    assign cap_got     = cap_got_q;
    assign cap_exp     = cap_exp_q;

`ifdef ALU_CHK_SIGNATURE_EN
    logic [WIDTH-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (s2_valid_q) begin
            sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ s2_got_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances share stimulus (STOP_ON_FAIL=0 with 32-bit
// counters, STOP_ON_FAIL=1 with 3-bit counters so saturation is reachable). A queue-based
// model predicts every output each cycle; literal checks pin the model.
module tb_alu_result_checker;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] op_a = '0, op_b = '0, alu_out = '0;
    logic [1:0]  op_cont = '0;

    logic        in_ready_w [2];
    logic        busy_w [2];
    logic        fail_flag_w [2];
    logic        halted_w [2];
    logic [63:0] cap_a_w [2], cap_b_w [2], cap_got_w [2], cap_exp_w [2];
    logic [1:0]  cap_cont_w [2];
    logic [31:0] checked0, fail0;
    logic [2:0]  checked1, fail1;
`ifdef ALU_CHK_SIGNATURE_EN
    logic [63:0] sig_w [2];
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.WIDTH(64), .CNT_W(32), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_w[0]), .op_a(op_a), .op_b(op_b), .op_cont(op_cont),
        .alu_out(alu_out), .busy(busy_w[0]), .checked_cnt(checked0), .fail_cnt(fail0),
        .fail_flag(fail_flag_w[0]), .halted(halted_w[0]), .cap_a(cap_a_w[0]),
        .cap_b(cap_b_w[0]), .cap_cont(cap_cont_w[0]), .cap_got(cap_got_w[0]),
        .cap_exp(cap_exp_w[0])
`ifdef ALU_CHK_SIGNATURE_EN
        , .sig(sig_w[0])
`endif
    );

    alu_result_checker #(.WIDTH(64), .CNT_W(3), .STOP_ON_FAIL(1'b1)) dut_stop (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_w[1]), .op_a(op_a), .op_b(op_b), .op_cont(op_cont),
        .alu_out(alu_out), .busy(busy_w[1]), .checked_cnt(checked1), .fail_cnt(fail1),
        .fail_flag(fail_flag_w[1]), .halted(halted_w[1]), .cap_a(cap_a_w[1]),
        .cap_b(cap_b_w[1]), .cap_cont(cap_cont_w[1]), .cap_got(cap_got_w[1]),
        .cap_exp(cap_exp_w[1])
`ifdef ALU_CHK_SIGNATURE_EN
        , .sig(sig_w[1])
`endif
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int          inst;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] got;
        logic [1:0]  cont;
        int          age;
    } tup_t;

    tup_t            pq[$];
    int              m_state [2];
    longint unsigned m_checked [2], m_fail [2];
    longint unsigned cnt_max [2] = '{64'hFFFF_FFFF, 64'd7};
    bit              stop_cfg [2] = '{1'b0, 1'b1};
    bit              m_flag [2];
    logic [63:0]     m_cap_a [2], m_cap_b [2], m_cap_got [2], m_cap_exp [2], m_sig [2];
    logic [1:0]      m_cap_cont [2];
    bit              model_live = 1'b0;

    function automatic logic [63:0] expect_res(input logic [63:0] a, b, input logic [1:0] c);
        case (c)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic void model_reset(input int k);
        m_state[k] = M_IDLE;
        m_checked[k] = 0;
        m_fail[k] = 0;
        m_flag[k] = 1'b0;
        m_cap_a[k] = '0;
        m_cap_b[k] = '0;
        m_cap_got[k] = '0;
        m_cap_exp[k] = '0;
        m_cap_cont[k] = '0;
        m_sig[k] = '0;
    endfunction

    function automatic void model_compare(input tup_t t);
        logic [63:0] e;
        int k;
        k = t.inst;
        e = expect_res(t.a, t.b, t.cont);
        if (m_checked[k] < cnt_max[k]) m_checked[k]++;
        if (t.got != e) begin
            if (m_fail[k] < cnt_max[k]) m_fail[k]++;
            if (!m_flag[k]) begin
                m_cap_a[k] = t.a;
                m_cap_b[k] = t.b;
                m_cap_cont[k] = t.cont;
                m_cap_got[k] = t.got;
                m_cap_exp[k] = e;
                m_flag[k] = 1'b1;
            end
            if (stop_cfg[k] && m_state[k] == M_RUN) m_state[k] = M_HALT;
        end
        m_sig[k] = ((m_sig[k] << 1) | (m_sig[k] >> 63)) ^ t.got;
    endfunction

    function automatic bit model_busy(input int k);
        foreach (pq[j]) if (pq[j].inst == k) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        tup_t nq[$];
        tup_t t;
        bit   acc [2];
        for (int k = 0; k < 2; k++) acc[k] = in_valid && (m_state[k] == M_RUN);
        if (!rst_n || clear) begin
            pq.delete();
            for (int k = 0; k < 2; k++) model_reset(k);
        end else begin
            nq.delete();
            foreach (pq[j]) begin
                t = pq[j];
                if (t.age == 2) begin
                    model_compare(t);
                end else begin
                    t.age = t.age + 1;
                    nq.push_back(t);
                end
            end
            pq = nq;
            for (int k = 0; k < 2; k++) begin
                if (m_state[k] == M_IDLE && start) m_state[k] = M_RUN;
                if (acc[k]) begin
                    t.inst = k;
                    t.a = op_a;
                    t.b = op_b;
                    t.got = alu_out;
                    t.cont = op_cont;
                    t.age = 1;
                    pq.push_back(t);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_checked(input int k);
        return (k == 0) ? 64'(checked0) : 64'(checked1);
    endfunction

    function automatic logic [63:0] dut_fail(input int k);
        return (k == 0) ? 64'(fail0) : 64'(fail1);
    endfunction

    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready[%0d]", i), 64'(in_ready_w[i]), 64'(m_state[i] == M_RUN));
                chk($sformatf("halted[%0d]", i), 64'(halted_w[i]), 64'(m_state[i] == M_HALT));
                chk($sformatf("busy[%0d]", i), 64'(busy_w[i]), 64'(model_busy(i)));
                chk($sformatf("checked[%0d]", i), dut_checked(i), m_checked[i]);
                chk($sformatf("fail_cnt[%0d]", i), dut_fail(i), m_fail[i]);
                chk($sformatf("fail_flag[%0d]", i), 64'(fail_flag_w[i]), 64'(m_flag[i]));
                chk($sformatf("cap_a[%0d]", i), cap_a_w[i], m_cap_a[i]);
                chk($sformatf("cap_b[%0d]", i), cap_b_w[i], m_cap_b[i]);
                chk($sformatf("cap_cont[%0d]", i), 64'(cap_cont_w[i]), 64'(m_cap_cont[i]));
                chk($sformatf("cap_got[%0d]", i), cap_got_w[i], m_cap_got[i]);
                chk($sformatf("cap_exp[%0d]", i), cap_exp_w[i], m_cap_exp[i]);
`ifdef ALU_CHK_SIGNATURE_EN
                chk($sformatf("sig[%0d]", i), sig_w[i], m_sig[i]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic drive(input logic [63:0] a, b, input logic [1:0] c, input logic [63:0] o);
        @(negedge clk);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_cont = c;
        alu_out = o;
    endtask

    task automatic drain();
        @(negedge clk) in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [63:0] b2b_out [4] = '{64'd70, 64'd30, 64'd16, 64'd54};
    logic [63:0] sat_out [4] = '{64'd10, 64'd4, 64'd3, 64'd7};

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        model_live = 1'b1;
        chk("rst_checked", 64'(checked0), 64'd0);
        chk("rst_busy", 64'(busy_w[0]), 64'd0);
        chk("rst_in_ready", 64'(in_ready_w[0]), 64'd0);
        chk("rst_halted", 64'(halted_w[0]), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // single OR op
        pulse_start();
        drive(64'd50, 64'd20, 2'b11, 64'd54);
        drain();
        chk("t1_checked", 64'(checked0), 64'd1);
        chk("t1_fail", 64'(fail0), 64'd0);
        chk("t1_flag", 64'(fail_flag_w[0]), 64'd0);

        // back-to-back, all four opcodes
        for (int i = 0; i < 4; i++) begin
            drive(64'd50, 64'd20, 2'(i), b2b_out[i]);
            chk("b2b_in_ready", 64'(in_ready_w[0]), 64'd1);
        end
        drain();
        chk("t2_checked", 64'(checked0), 64'd5);
        chk("t2_fail", 64'(fail0), 64'd0);
        chk("t2_checked_small", 64'(checked1), 64'd5);

        // 3-bit counter saturates at 7
        for (int i = 0; i < 4; i++) drive(64'd7, 64'd3, 2'(i), sat_out[i]);
        drain();
        chk("sat_checked_wide", 64'(checked0), 64'd9);
        chk("sat_checked_small", 64'(checked1), 64'd7);

        // failures: bad, good, good, bad
        pulse_clear();
        pulse_start();
        drive(ONES, 64'd1, 2'b00, 64'd5);
        drive(64'd50, 64'd20, 2'b00, 64'd70);
        drive(64'd50, 64'd20, 2'b01, 64'd30);
        drive(64'd3, 64'd1, 2'b00, 64'd9);
        drain();
        chk("t3_fail", 64'(fail0), 64'd2);
        chk("t3_checked", 64'(checked0), 64'd4);
        chk("t3_cap_exp", cap_exp_w[0], 64'd0);
        chk("t3_cap_got", cap_got_w[0], 64'd5);
        chk("t3_cap_a", cap_a_w[0], ONES);
        chk("t3_cap_b", cap_b_w[0], 64'd1);
        chk("t3_stop_halted", 64'(halted_w[1]), 64'd1);
        chk("t3_stop_in_ready", 64'(in_ready_w[1]), 64'd0);
        chk("t3_stop_checked", 64'(checked1), 64'd3);
        chk("t3_stop_fail", 64'(fail1), 64'd1);
        pulse_start();
        chk("t3_start_in_halt", 64'(halted_w[1]), 64'd1);

        // clear while busy drops in-flight tuples
        drive(64'd1, 64'd2, 2'b00, 64'd3);
        drive(64'd1, 64'd2, 2'b00, 64'd4);
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        chk("t4_busy_before", 64'(busy_w[0]), 64'd1);
        @(negedge clk) clear = 1'b0;
        chk("t4_checked", 64'(checked0), 64'd0);
        chk("t4_fail", 64'(fail0), 64'd0);
        chk("t4_flag", 64'(fail_flag_w[0]), 64'd0);
        chk("t4_busy", 64'(busy_w[0]), 64'd0);
        chk("t4_idle", 64'(in_ready_w[0]), 64'd0);
        chk("t4_unhalted", 64'(halted_w[1]), 64'd0);

        // start and clear together stay idle
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("t5_idle0", 64'(in_ready_w[0]), 64'd0);
        chk("t5_idle1", 64'(in_ready_w[1]), 64'd0);

        // subtraction wraps modulo 2^64
        pulse_start();
        drive(64'd20, 64'd50, 2'b01, 64'hFFFF_FFFF_FFFF_FFE2);
        drain();
        chk("t6_checked", 64'(checked0), 64'd1);
        chk("t6_fail", 64'(fail0), 64'd0);
`ifdef ALU_CHK_SIGNATURE_EN
        chk("t6_sig", sig_w[0], 64'hFFFF_FFFF_FFFF_FFE2);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
